// File: rtl/regfile_scoreboard.sv
// Register file with two async read ports, one sync write port, optional
// hard-zero r0, write-to-read bypass and a per-register pending scoreboard.
module regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    output logic              ReadValid1,
    output logic              ReadValid2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] IssueRegister,
    input  logic              IssueValid,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic [ADDR_W:0]  count_q;
    logic [ADDR_W:0]  count_d;

    logic wr_en;
    logic iss_en;
    logic rd1_zero;
    logic rd2_zero;
    logic byp1;
    logic byp2;

    assign wr_en  = RegWrite   && !((ZERO_REG != 0) && (WriteRegister == '0));
    assign iss_en = IssueValid && !((ZERO_REG != 0) && (IssueRegister == '0));

    assign rd1_zero = (ZERO_REG != 0) && (ReadRegister1 == '0);
    assign rd2_zero = (ZERO_REG != 0) && (ReadRegister2 == '0);

    // wr_en already excludes the hard-zero register, so a bypass hit never
    // claims r0 as valid through the write path.
    assign byp1 = (BYPASS != 0) && wr_en && (WriteRegister == ReadRegister1);
    assign byp2 = (BYPASS != 0) && wr_en && (WriteRegister == ReadRegister2);

    // Issue is applied after the write clear: the issuing instruction is the
    // newer producer, so a same-cycle collision leaves the flag set.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[WriteRegister] = 1'b0;
        end
        if (iss_en) begin
            pending_d[IssueRegister] = 1'b1;
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{ADDR_W{1'b0}}, pending_d[i]};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[WriteRegister] <= WriteData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        if (rd1_zero) begin
            ReadData1 = '0;
        end else if (byp1) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = regs_q[ReadRegister1];
        end
    end

    always_comb begin
        if (rd2_zero) begin
            ReadData2 = '0;
        end else if (byp2) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = regs_q[ReadRegister2];
        end
    end

    assign ReadValid1   = !pending_q[ReadRegister1] || byp1;
    assign ReadValid2   = !pending_q[ReadRegister2] || byp2;
    assign PendingCount = count_q;

endmodule
